// File: rtl/lampfpu_op_checker.sv
// lampfpu_op_checker: queued request sequencer and result checker for lampFPU_top.
// Requests are buffered in a small FIFO and issued one at a time to the FPU.
// Each result is compared against its expected value. Pass/fail counts, a sticky
// error flag and a first-failure record are kept, and a watchdog catches FPU hangs.
module lampfpu_op_checker #(
  parameter int LAMP_FLOAT_DW   = 16,
  parameter int LAMP_INTEGER_DW = 32,
  parameter int OPCODE_W        = 4,
  parameter int IDLE_OPCODE     = 0,
  parameter int DEPTH           = 4,
  parameter int CNT_W           = 16,
  parameter int TIMEOUT         = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [OPCODE_W-1:0]        req_opcode_i,
  input  logic [LAMP_INTEGER_DW-1:0] req_op1_i,
  input  logic [LAMP_FLOAT_DW-1:0]   req_op2_i,
  input  logic [LAMP_INTEGER_DW-1:0] req_exp_i,
  input  logic [1:0]                 req_mode_i,
  output logic [OPCODE_W-1:0]        fpu_opcode_o,
  output logic [LAMP_INTEGER_DW-1:0] fpu_op1_o,
  output logic [LAMP_FLOAT_DW-1:0]   fpu_op2_o,
  output logic                       fpu_flush_o,
  output logic                       fpu_padv_o,
  input  logic [LAMP_INTEGER_DW-1:0] fpu_result_i,
  input  logic                       fpu_valid_i,
  input  logic                       fpu_ready_i,
  output logic                       busy_o,
  output logic [CNT_W-1:0]           pass_cnt_o,
  output logic [CNT_W-1:0]           fail_cnt_o,
  output logic                       err_o,
  output logic [CNT_W-1:0]           ff_idx_o,
  output logic [LAMP_INTEGER_DW-1:0] ff_res_o,
  output logic [LAMP_INTEGER_DW-1:0] ff_exp_o,
  output logic                       ff_tmo_o
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam int EXP_W  = 8;
  localparam int FRAC_W = LAMP_FLOAT_DW - 1 - EXP_W;

  localparam logic [OPCODE_W-1:0] IDLE_OP = OPCODE_W'(IDLE_OPCODE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_CHECK = 2'd3;

  localparam logic [1:0] MODE_FLOAT     = 2'd0;
  localparam logic [1:0] MODE_INT       = 2'd1;
  localparam logic [1:0] MODE_BOOL      = 2'd2;
  localparam logic [1:0] MODE_FLOAT_NAN = 2'd3;

  // ---------------------------------------------------------------- FIFO
  logic [OPCODE_W-1:0]        r_mem_opc  [DEPTH];
  logic [LAMP_INTEGER_DW-1:0] r_mem_op1  [DEPTH];
  logic [LAMP_FLOAT_DW-1:0]   r_mem_op2  [DEPTH];
  logic [LAMP_INTEGER_DW-1:0] r_mem_exp  [DEPTH];
  logic [1:0]                 r_mem_mode [DEPTH];

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_nxt;
  logic          r_req_ready;
  logic          w_push;
  logic          w_pop;

  // ---------------------------------------------------------------- FSM / holding
  logic [1:0]                 r_state;
  logic [OPCODE_W-1:0]        r_fpu_opc;
  logic [LAMP_INTEGER_DW-1:0] r_op1;
  logic [LAMP_FLOAT_DW-1:0]   r_op2;
  logic [LAMP_INTEGER_DW-1:0] r_exp;
  logic [1:0]                 r_mode;
  logic [LAMP_INTEGER_DW-1:0] r_res;
  logic [TW-1:0]              r_wcnt;
  logic                       r_flush;

  // ---------------------------------------------------------------- statistics
  logic [CNT_W-1:0]           r_seq;
  logic [CNT_W-1:0]           r_pass_cnt;
  logic [CNT_W-1:0]           r_fail_cnt;
  logic                       r_err;
  logic [CNT_W-1:0]           r_ff_idx;
  logic [LAMP_INTEGER_DW-1:0] r_ff_res;
  logic [LAMP_INTEGER_DW-1:0] r_ff_exp;
  logic                       r_ff_tmo;

  logic w_tmo_hit;
  logic w_chk_done;
  logic w_tmo_done;
  logic w_done;
  logic w_match;
  logic w_fail;

  logic [LAMP_FLOAT_DW-1:0] w_res_f;
  logic [LAMP_FLOAT_DW-1:0] w_exp_f;

  function automatic logic is_nan(input logic [LAMP_FLOAT_DW-1:0] f);
    return (&f[LAMP_FLOAT_DW-2 -: EXP_W]) && (|f[FRAC_W-1:0]);
  endfunction

  assign w_push = req_valid_i & r_req_ready;
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0) && fpu_ready_i;

  // Next occupancy; simultaneous push and pop leaves it unchanged
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_opc[r_wptr]  <= req_opcode_i;
      r_mem_op1[r_wptr]  <= req_op1_i;
      r_mem_op2[r_wptr]  <= req_op2_i;
      r_mem_exp[r_wptr]  <= req_exp_i;
      r_mem_mode[r_wptr] <= req_mode_i;
    end
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_req_ready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count     <= w_count_nxt;
      r_req_ready <= (w_count_nxt != (AW+1)'(DEPTH));
    end
  end

  // Watchdog fires on the last permitted WAIT cycle when no result arrived
  assign w_tmo_hit  = (r_state == S_WAIT) && !fpu_valid_i && (r_wcnt == TW'(TIMEOUT - 1));
  assign w_chk_done = (r_state == S_CHECK);
  assign w_tmo_done = w_tmo_hit;
  assign w_done     = w_chk_done | w_tmo_done;

  // Issue/wait/check sequencing; r_wcnt counts cycles since the issue cycle,
  // so the flush pulse lands exactly TIMEOUT cycles after the opcode went out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_fpu_opc <= IDLE_OP;
      r_op1     <= '0;
      r_op2     <= '0;
      r_exp     <= '0;
      r_mode    <= '0;
      r_res     <= '0;
      r_wcnt    <= '0;
      r_flush   <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_fpu_opc <= r_mem_opc[r_rptr];
            r_op1     <= r_mem_op1[r_rptr];
            r_op2     <= r_mem_op2[r_rptr];
            r_exp     <= r_mem_exp[r_rptr];
            r_mode    <= r_mem_mode[r_rptr];
            r_wcnt    <= '0;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_fpu_opc <= IDLE_OP;
          r_wcnt    <= r_wcnt + TW'(1);
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (fpu_valid_i) begin
            r_res   <= fpu_result_i;
            r_state <= S_CHECK;
          end else if (w_tmo_hit) begin
            r_flush <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wcnt <= r_wcnt + TW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_res_f = r_res[LAMP_FLOAT_DW-1:0];
  assign w_exp_f = r_exp[LAMP_FLOAT_DW-1:0];

  // Result comparison according to the stored compare mode
  always_comb begin
    w_match = 1'b0;
    case (r_mode)
      MODE_FLOAT:     w_match = (w_res_f == w_exp_f);
      MODE_INT:       w_match = (r_res == r_exp);
      MODE_BOOL:      w_match = (r_res[0] == r_exp[0]);
      MODE_FLOAT_NAN: w_match = (w_res_f == w_exp_f) || (is_nan(w_res_f) && is_nan(w_exp_f));
      default:        w_match = 1'b0;
    endcase
  end

  assign w_fail = w_tmo_done | (w_chk_done & !w_match);

  // Counters, sticky error and first-failure record; clear overrides a same-cycle update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seq      <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_err      <= 1'b0;
      r_ff_idx   <= '0;
      r_ff_res   <= '0;
      r_ff_exp   <= '0;
      r_ff_tmo   <= 1'b0;
    end else if (clear_i) begin
      r_seq      <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_err      <= 1'b0;
      r_ff_idx   <= '0;
      r_ff_res   <= '0;
      r_ff_exp   <= '0;
      r_ff_tmo   <= 1'b0;
    end else if (w_done) begin
      r_seq <= r_seq + CNT_W'(1);
      if (w_fail) begin
        if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
        if (!r_err) begin
          r_err    <= 1'b1;
          r_ff_idx <= r_seq;
          r_ff_res <= w_tmo_done ? '0 : r_res;
          r_ff_exp <= r_exp;
          r_ff_tmo <= w_tmo_done;
        end
      end else begin
        if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
      end
    end
  end

  assign req_ready_o  = r_req_ready;
  assign fpu_opcode_o = r_fpu_opc;
  assign fpu_op1_o    = r_op1;
  assign fpu_op2_o    = r_op2;
  assign fpu_flush_o  = r_flush;
  assign fpu_padv_o   = 1'b1;
  assign busy_o       = (r_count != '0) || (r_state != S_IDLE);
  assign pass_cnt_o   = r_pass_cnt;
  assign fail_cnt_o   = r_fail_cnt;
  assign err_o        = r_err;
  assign ff_idx_o     = r_ff_idx;
  assign ff_res_o     = r_ff_res;
  assign ff_exp_o     = r_ff_exp;
  assign ff_tmo_o     = r_ff_tmo;

endmodule

// File: tb/tb_lampfpu_op_checker.sv
// Testbench for lampfpu_op_checker: table of directed operations with a
// bench-side FPU responder, plus sequences for timeout, FIFO fill, reset and clear.
module tb_lampfpu_op_checker;

  localparam int FDW     = 16;
  localparam int IDW     = 32;
  localparam int OW      = 4;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic           clear_i;
  logic           req_valid_i;
  logic           req_ready_o;
  logic [OW-1:0]  req_opcode_i;
  logic [IDW-1:0] req_op1_i;
  logic [FDW-1:0] req_op2_i;
  logic [IDW-1:0] req_exp_i;
  logic [1:0]     req_mode_i;
  logic [OW-1:0]  fpu_opcode_o;
  logic [IDW-1:0] fpu_op1_o;
  logic [FDW-1:0] fpu_op2_o;
  logic           fpu_flush_o;
  logic           fpu_padv_o;
  logic [IDW-1:0] fpu_result_i;
  logic           fpu_valid_i;
  logic           fpu_ready_i;
  logic           busy_o;
  logic [CNT_W-1:0] pass_cnt_o;
  logic [CNT_W-1:0] fail_cnt_o;
  logic           err_o;
  logic [CNT_W-1:0] ff_idx_o;
  logic [IDW-1:0] ff_res_o;
  logic [IDW-1:0] ff_exp_o;
  logic           ff_tmo_o;

  lampfpu_op_checker #(
    .LAMP_FLOAT_DW(FDW), .LAMP_INTEGER_DW(IDW), .OPCODE_W(OW), .IDLE_OPCODE(0),
    .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_opcode_i(req_opcode_i), .req_op1_i(req_op1_i), .req_op2_i(req_op2_i),
    .req_exp_i(req_exp_i), .req_mode_i(req_mode_i),
    .fpu_opcode_o(fpu_opcode_o), .fpu_op1_o(fpu_op1_o), .fpu_op2_o(fpu_op2_o),
    .fpu_flush_o(fpu_flush_o), .fpu_padv_o(fpu_padv_o),
    .fpu_result_i(fpu_result_i), .fpu_valid_i(fpu_valid_i), .fpu_ready_i(fpu_ready_i),
    .busy_o(busy_o), .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o), .err_o(err_o),
    .ff_idx_o(ff_idx_o), .ff_res_o(ff_res_o), .ff_exp_o(ff_exp_o), .ff_tmo_o(ff_tmo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0]  opc;
    logic [IDW-1:0] op1;
    logic [FDW-1:0] op2;
    logic [IDW-1:0] exp;
    logic [1:0]     mode;
    logic [IDW-1:0] res;
    int             lat;
    bit             pass;
  } vec_t;

  vec_t tbl [11];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [IDW-1:0] act, input logic [IDW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [OW-1:0] opc, input logic [IDW-1:0] op1,
                      input logic [FDW-1:0] op2, input logic [IDW-1:0] expv,
                      input logic [1:0] mode);
    int n = 0;
    while (!req_ready_o && n < 100) begin tick(); n++; end
    if (!req_ready_o) begin
      chk("push_ready_timeout", 32'(req_ready_o), 32'd1);
      return;
    end
    req_opcode_i = opc; req_op1_i = op1; req_op2_i = op2;
    req_exp_i = expv; req_mode_i = mode; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
  endtask

  // Waits (bounded) until the opcode appears; leaves time in the issue cycle
  task automatic wait_issue(output bit ok, output logic [IDW-1:0] op1, output logic [FDW-1:0] op2);
    int n = 0;
    while (fpu_opcode_o == '0 && n < 200) begin tick(); n++; end
    ok  = (fpu_opcode_o != '0);
    op1 = fpu_op1_o;
    op2 = fpu_op2_o;
    if (!ok) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  // Bench FPU: return res lat cycles after the issue cycle
  task automatic serve(input logic [IDW-1:0] res, input int lat,
                       output logic [IDW-1:0] op1, output logic [FDW-1:0] op2);
    bit ok;
    wait_issue(ok, op1, op2);
    if (!ok) return;
    repeat (lat) tick();
    fpu_result_i = res; fpu_valid_i = 1'b1;
    tick();
    fpu_valid_i = 1'b0; fpu_result_i = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 200) begin tick(); n++; end
    if (busy_o) chk("idle_timeout", 32'(busy_o), 32'd0);
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [IDW-1:0] s_op1;
    logic [FDW-1:0] s_op2;
    bit             ok;
    int             exp_pass;
    int             exp_fail;
    int             first_fail;
    int             cyc;
    int             acc;
    logic           rdy;

    tbl[0]  = '{4'h1, 32'h3F80, 16'h3F80, 32'h4000,     2'd0, 32'h4000,     2, 1'b1};
    tbl[1]  = '{4'h9, 32'h0011, 16'h0022, 32'h1,        2'd2, 32'hFFFE,     1, 1'b0};
    tbl[2]  = '{4'h2, 32'h7FC0, 16'h3F80, 32'h7FC0,     2'd3, 32'hFFC1,     3, 1'b1};
    tbl[3]  = '{4'h2, 32'h7FC0, 16'h3F80, 32'h7FC0,     2'd0, 32'hFFC1,     3, 1'b0};
    tbl[4]  = '{4'h5, 32'h1234, 16'h0001, 32'h12345678, 2'd1, 32'h12345678, 4, 1'b1};
    tbl[5]  = '{4'h5, 32'h1235, 16'h0002, 32'h12345678, 2'd1, 32'h12345679, 5, 1'b0};
    tbl[6]  = '{4'h3, 32'h4040, 16'hBF80, 32'h3F80,     2'd0, 32'hABCD3F80, 1, 1'b1};
    tbl[7]  = '{4'hA, 32'h0001, 16'h0002, 32'h0,        2'd2, 32'h2,        2, 1'b1};
    tbl[8]  = '{4'h4, 32'h7F80, 16'h3F80, 32'h7F80,     2'd3, 32'h7F80,     2, 1'b1};
    tbl[9]  = '{4'h4, 32'h7F80, 16'h0000, 32'h7FC0,     2'd3, 32'h7F80,     1, 1'b0};
    tbl[10] = '{4'h6, 32'h0000, 16'h0000, 32'hFF81,     2'd3, 32'h7FFF,     3, 1'b1};

    rst = 1'b0; clear_i = 1'b0; req_valid_i = 1'b0;
    req_opcode_i = '0; req_op1_i = '0; req_op2_i = '0; req_exp_i = '0; req_mode_i = '0;
    fpu_result_i = '0; fpu_valid_i = 1'b0; fpu_ready_i = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready_o), 32'd0);
    chk("rst_opcode",    32'(fpu_opcode_o), 32'd0);
    chk("rst_padv",      32'(fpu_padv_o), 32'd1);
    chk("rst_flush",     32'(fpu_flush_o), 32'd0);
    chk("rst_busy",      32'(busy_o), 32'd0);
    chk("rst_pass",      32'(pass_cnt_o), 32'd0);
    chk("rst_err",       32'(err_o), 32'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_ready", 32'(req_ready_o), 32'd1);

    // Directed table
    exp_pass = 0; exp_fail = 0; first_fail = -1;
    for (int i = 0; i < 11; i++) begin
      push(tbl[i].opc, tbl[i].op1, tbl[i].op2, tbl[i].exp, tbl[i].mode);
      serve(tbl[i].res, tbl[i].lat, s_op1, s_op2);
      wait_idle();
      if (tbl[i].pass) exp_pass++;
      else begin
        exp_fail++;
        if (first_fail < 0) first_fail = i;
      end
      chk($sformatf("tbl%0d_op1", i), s_op1, tbl[i].op1);
      chk($sformatf("tbl%0d_op2", i), 32'(s_op2), 32'(tbl[i].op2));
      chk($sformatf("tbl%0d_pass_cnt", i), 32'(pass_cnt_o), 32'(exp_pass));
      chk($sformatf("tbl%0d_fail_cnt", i), 32'(fail_cnt_o), 32'(exp_fail));
    end
    chk("tbl_err",    32'(err_o), 32'd1);
    chk("tbl_ff_idx", 32'(ff_idx_o), 32'(first_fail));
    chk("tbl_ff_res", ff_res_o, tbl[first_fail].res);
    chk("tbl_ff_exp", ff_exp_o, tbl[first_fail].exp);
    chk("tbl_ff_tmo", 32'(ff_tmo_o), 32'd0);

    // clear_i zeroes statistics
    do_clear();
    chk("clr_pass", 32'(pass_cnt_o), 32'd0);
    chk("clr_fail", 32'(fail_cnt_o), 32'd0);
    chk("clr_err",  32'(err_o), 32'd0);
    chk("clr_ff_res", ff_res_o, 32'd0);

    // Timeout: first op never answered, second op follows normally
    push(4'h2, 32'h11, 16'h0, 32'h1234, 2'd1);
    push(4'h3, 32'h22, 16'h0, 32'h4000, 2'd0);
    wait_issue(ok, s_op1, s_op2);
    chk("tmo_issue_op1", s_op1, 32'h11);
    cyc = 0;
    while (!fpu_flush_o && cyc < 200) begin tick(); cyc++; end
    chk("tmo_flush_delay", 32'(cyc), 32'(TIMEOUT));
    chk("tmo_fail_cnt", 32'(fail_cnt_o), 32'd1);
    chk("tmo_ff_tmo",   32'(ff_tmo_o), 32'd1);
    chk("tmo_err",      32'(err_o), 32'd1);
    chk("tmo_ff_res",   ff_res_o, 32'd0);
    chk("tmo_ff_exp",   ff_exp_o, 32'h1234);
    chk("tmo_ff_idx",   32'(ff_idx_o), 32'd0);
    tick();
    chk("tmo_flush_one_cycle", 32'(fpu_flush_o), 32'd0);
    serve(32'h4000, 2, s_op1, s_op2);
    wait_idle();
    chk("tmo_next_op1", s_op1, 32'h22);
    chk("tmo_next_pass", 32'(pass_cnt_o), 32'd1);
    chk("tmo_next_fail", 32'(fail_cnt_o), 32'd1);

    // FIFO fill with the FPU not ready
    do_clear();
    fpu_ready_i = 1'b0;
    acc = 0;
    req_valid_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_opcode_i = 4'h1; req_op1_i = 32'h100 + 32'(acc); req_op2_i = '0;
      req_exp_i = 32'h3F00 + 32'(acc); req_mode_i = 2'd0;
      rdy = req_ready_o;
      tick();
      if (rdy) acc++;
    end
    req_valid_i = 1'b0;
    chk("fifo_accepts",  32'(acc), 32'(DEPTH));
    chk("fifo_ready_lo", 32'(req_ready_o), 32'd0);
    chk("fifo_busy",     32'(busy_o), 32'd1);
    chk("fifo_no_issue", 32'(fpu_opcode_o), 32'd0);
    fpu_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      serve(32'h3F00 + 32'(i), 1 + i, s_op1, s_op2);
      chk($sformatf("fifo_order%0d", i), s_op1, 32'h100 + 32'(i));
    end
    wait_idle();
    chk("fifo_pass", 32'(pass_cnt_o), 32'(DEPTH));
    chk("fifo_fail", 32'(fail_cnt_o), 32'd0);

    // Asynchronous reset in the middle of WAIT with another op queued
    push(4'h5, 32'h55, 16'h1, 32'h0, 2'd1);
    push(4'h6, 32'h66, 16'h2, 32'h0, 2'd1);
    wait_issue(ok, s_op1, s_op2);
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("amid_busy",   32'(busy_o), 32'd0);
    chk("amid_ready",  32'(req_ready_o), 32'd0);
    chk("amid_op1",    fpu_op1_o, 32'd0);
    chk("amid_op2",    32'(fpu_op2_o), 32'd0);
    chk("amid_pass",   32'(pass_cnt_o), 32'd0);
    chk("amid_padv",   32'(fpu_padv_o), 32'd1);
    tick();
    rst = 1'b1;
    tick(); tick(); tick();
    chk("arst_fifo_empty", 32'(busy_o), 32'd0);
    chk("arst_no_issue",   32'(fpu_opcode_o), 32'd0);

    // clear_i coinciding with CHECK drops that result
    push(4'h1, 32'h3F80, 16'h3F80, 32'h4000, 2'd0);
    serve(32'h4000, 1, s_op1, s_op2);
    wait_idle();
    chk("cchk_pre_pass", 32'(pass_cnt_o), 32'd1);
    push(4'h5, 32'h7, 16'h0, 32'h5, 2'd1);
    wait_issue(ok, s_op1, s_op2);
    tick();
    fpu_result_i = 32'h6; fpu_valid_i = 1'b1;
    tick();
    fpu_valid_i = 1'b0;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("cchk_pass", 32'(pass_cnt_o), 32'd0);
    chk("cchk_fail", 32'(fail_cnt_o), 32'd0);
    chk("cchk_err",  32'(err_o), 32'd0);
    chk("cchk_busy", 32'(busy_o), 32'd0);

    // BOOL failure straight after a clear records index 0
    push(4'h9, 32'h1, 16'h1, 32'h1, 2'd2);
    serve(32'hFFFE, 2, s_op1, s_op2);
    wait_idle();
    chk("bool_fail_cnt", 32'(fail_cnt_o), 32'd1);
    chk("bool_ff_idx",   32'(ff_idx_o), 32'd0);
    chk("bool_ff_res",   ff_res_o, 32'hFFFE);
    chk("bool_ff_exp",   ff_exp_o, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
